// File: rtl/ip_codma_mem_responder.sv
// ----------------------------------------------------------------------------
// ip_codma_mem_responder
//   Bus-side responder for the CODMA memory interface. Answers read and write
//   bursts from the DMA engine out of an internal word-addressed array, with
//   grant, programmable wait states, beat-by-beat data and error signalling.
//
// Ports
//   clk_i      clock
//   reset_n_i  asynchronous active-low reset
//   req_i      request valid; addr/size/we stable until gnt_o
//   we_i       1 = write burst, 0 = read burst
//   addr_i     byte start address (4-byte aligned)
//   size_i     burst code: 3 = 2 beats, 8 = 4 beats, 9 = 8 beats
//   wdata_i    write beat data
//   wvalid_i   write beat valid
//   wready_o   write beat accepted when wvalid_i && wready_o
//   rdata_o    read beat data (holds last value between beats)
//   rvalid_o   read beat valid, no back-pressure
//   gnt_o      one-cycle pulse: request accepted
//   done_o     one-cycle pulse with/after the last beat
//   error_o    one-cycle pulse: request rejected
//   busy_o     high from grant until done_o inclusive
// ----------------------------------------------------------------------------
module ip_codma_mem_responder #(
    parameter int          MEM_WORDS   = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  size_i,
    input  logic [31:0] wdata_i,
    input  logic        wvalid_i,
    output logic        wready_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        gnt_o,
    output logic        done_o,
    output logic        error_o,
    output logic        busy_o
);

    localparam int          IDX_W     = $clog2(MEM_WORDS);
    localparam logic [33:0] WIN_BYTES = 34'(MEM_WORDS) * 34'd4;
    localparam logic [3:0]  WAIT_LD   = 4'(WAIT_CYCLES);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WAIT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic [31:0]      mem [MEM_WORDS];

    logic [2:0]       state;
    logic [3:0]       wcnt;
    logic [3:0]       beat;
    logic [3:0]       nbeats;
    logic             we_q;
    logic [IDX_W-1:0] idx;

    // ------------------------------------------------------------------
    // Request legality, evaluated combinationally while idle
    // ------------------------------------------------------------------
    logic [3:0]  req_beats;
    logic        size_ok;
    logic [33:0] req_off;
    logic        req_legal;

    always_comb begin
        size_ok   = 1'b1;
        req_beats = 4'd0;
        case (size_i)
            4'd3:    req_beats = 4'd2;
            4'd8:    req_beats = 4'd4;
            4'd9:    req_beats = 4'd8;
            default: size_ok   = 1'b0;
        endcase
        // 34-bit offset: bit 33 flags an address below the window, and the
        // end-of-burst sum cannot overflow.
        req_off   = {2'b00, addr_i} - {2'b00, BASE_ADDR};
        req_legal = size_ok && (addr_i[1:0] == 2'b00) && !req_off[33] &&
                    ((req_off + {28'd0, req_beats, 2'b00}) <= WIN_BYTES);
    end

    // ------------------------------------------------------------------
    // Array write port (contents are deliberately not reset)
    // ------------------------------------------------------------------
    logic wr_fire;
    assign wr_fire = (state == S_WR) && wvalid_i && wready_o;

    always_ff @(posedge clk_i) begin
        if (wr_fire) mem[idx] <= wdata_i;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state    <= S_IDLE;
            gnt_o    <= 1'b0;
            rvalid_o <= 1'b0;
            wready_o <= 1'b0;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            busy_o   <= 1'b0;
            rdata_o  <= '0;
            wcnt     <= '0;
            beat     <= '0;
            nbeats   <= '0;
            we_q     <= 1'b0;
            idx      <= '0;
        end else begin
            gnt_o    <= 1'b0;
            done_o   <= 1'b0;
            error_o  <= 1'b0;
            rvalid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    // The done cycle is already spent in IDLE, so a held
                    // request is granted in the cycle right after done_o.
                    busy_o <= 1'b0;
                    if (req_i) begin
                        if (req_legal) begin
                            state  <= S_WAIT;
                            gnt_o  <= 1'b1;
                            busy_o <= 1'b1;
                            wcnt   <= WAIT_LD;
                            beat   <= '0;
                            nbeats <= req_beats;
                            we_q   <= we_i;
                            idx    <= req_off[IDX_W+1:2];
                        end else begin
                            state   <= S_ERR;
                            error_o <= 1'b1;
                        end
                    end
                end
                S_WAIT: begin
                    // wcnt holds wait cycles left, the grant cycle included;
                    // 0 and 1 both mean data starts in the next cycle.
                    if (wcnt <= 4'd1) begin
                        if (we_q) begin
                            state    <= S_WR;
                            wready_o <= 1'b1;
                        end else begin
                            // First read beat is issued on the way out so the
                            // data phase starts without a bubble.
                            state    <= S_RD;
                            rvalid_o <= 1'b1;
                            rdata_o  <= mem[idx];
                            idx      <= idx + 1'b1;
                            beat     <= 4'd1;
                        end
                    end else begin
                        wcnt <= wcnt - 4'd1;
                    end
                end
                S_RD: begin
                    rvalid_o <= 1'b1;
                    rdata_o  <= mem[idx];
                    idx      <= idx + 1'b1;
                    beat     <= beat + 4'd1;
                    if (beat + 4'd1 == nbeats) begin
                        done_o <= 1'b1;
                        state  <= S_IDLE;
                    end
                end
                S_WR: begin
                    if (wr_fire) begin
                        idx  <= idx + 1'b1;
                        beat <= beat + 4'd1;
                        if (beat + 4'd1 == nbeats) begin
                            wready_o <= 1'b0;
                            done_o   <= 1'b1;
                            state    <= S_IDLE;
                        end
                    end
                end
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
